mem_arbiter: RTL and testbench

Single-clock controller that owns one dual-port word memory (WORD_SIZE × 2^ADDR_SIZE, registered read, rena/wena enables) and shares it between two requesters. After reset it sweeps every address to zero, then arbitrates one access per cycle with round-robin priority. Read data returns one cycle after the grant. It sits between two client blocks and the memory instance; the memory's rclk and wclk are both tied to this block's clk.

---
 rtl/mem_arbiter_if.sv | 24 ++
 rtl/mem_arbiter.sv | 59 +++++
 tb/tb_mem_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two-requester access ports plus the memory port; slave = arbiter side, master = client/memory side
interface mem_arbiter_if #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 3
);
  logic                 req0, req1, we0, we1;
  logic [ADDR_SIZE-1:0] addr0, addr1;
  logic [WORD_SIZE-1:0] wdata0, wdata1;
  logic                 gnt0, gnt1, rvalid0, rvalid1, init_done;
  logic [WORD_SIZE-1:0] rdata0, rdata1;
  logic [ADDR_SIZE-1:0] m_w_addr, m_r_addr;
  logic [WORD_SIZE-1:0] m_w_word, m_r_word;
  logic                 m_wena, m_rena;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, m_r_word,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, init_done,
           m_w_addr, m_w_word, m_wena, m_r_addr, m_rena
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, m_r_word,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, init_done,
           m_w_addr, m_w_word, m_wena, m_r_addr, m_rena
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: zero-sweeps the memory after reset, then round-robin arbitrates one access per cycle between two ports (clk, rst_n, bus_io)
module mem_arbiter #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus_io
);
  typedef enum logic {INIT, RUN} state_e;
  localparam logic [ADDR_SIZE-1:0] CNT_LAST = '1;
  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d, addr;
  logic [WORD_SIZE-1:0] wdata;
  logic                 prio_q, prio_d, rv0_q, rv0_d, rv1_q, rv1_d;
  logic                 run, g0, g1, gnt, we;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end
  always_comb begin
    run     = rst_n && state_q == RUN;
    g0      = run && bus_io.req0 && (!bus_io.req1 || !prio_q);
    g1      = run && bus_io.req1 && (!bus_io.req0 || prio_q);
    gnt     = g0 || g1;
    addr    = g1 ? bus_io.addr1 : bus_io.addr0;
    wdata   = g1 ? bus_io.wdata1 : bus_io.wdata0;
    we      = g1 ? bus_io.we1 : bus_io.we0;
    state_d = (state_q == INIT && cnt_q == CNT_LAST) ? RUN : state_q;
    cnt_d   = state_q == INIT ? cnt_q + 1'b1 : cnt_q;
    prio_d  = g0 ? 1'b1 : g1 ? 1'b0 : prio_q;
    rv0_d   = g0 && !we;
    rv1_d   = g1 && !we;
  end
  // memory controls are gated by rst_n so an async reset silences the port at once
  assign bus_io.gnt0      = g0;
  assign bus_io.gnt1      = g1;
  assign bus_io.rvalid0   = rv0_q;
  assign bus_io.rvalid1   = rv1_q;
  assign bus_io.rdata0    = bus_io.m_r_word;
  assign bus_io.rdata1    = bus_io.m_r_word;
  assign bus_io.init_done = state_q == RUN;
  assign bus_io.m_wena    = rst_n && (state_q == INIT || (gnt && we));
  assign bus_io.m_w_addr  = !rst_n ? '0 : state_q == INIT ? cnt_q : addr;
  assign bus_io.m_w_word  = run ? wdata : '0;
  assign bus_io.m_rena    = gnt && !we;
  assign bus_io.m_r_addr  = run ? addr : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a behavioural registered-read memory
module tb_mem_arbiter;
  typedef struct {logic p; logic [7:0] d;} exp_t;
  logic clk, rst_n;
  int   tests, fails;
  exp_t q[$];
  logic [7:0] mem [8];
  mem_arbiter_if #(.WORD_SIZE(8), .ADDR_SIZE(3)) bus();
  mem_arbiter #(.WORD_SIZE(8), .ADDR_SIZE(3)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial for (int i = 0; i < 8; i++) mem[i] = 8'hFF;
  always @(posedge clk) begin
    if (bus.m_wena) mem[bus.m_w_addr] <= bus.m_w_word;
    if (bus.m_rena) bus.m_r_word <= mem[bus.m_r_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r0, w0, input logic [2:0] a0, input logic [7:0] d0,
                      input logic r1, w1, input logic [2:0] a1, input logic [7:0] d1,
                      input logic eg0, eg1, input logic [7:0] er);
    exp_t e;
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rvalid0", bus.rvalid0, !e.p);
      chk("rvalid1", bus.rvalid1, e.p);
      chk("rdata", e.p ? bus.rdata1 : bus.rdata0, e.d);
    end else begin
      chk("rvalid0_idle", bus.rvalid0, 0);
      chk("rvalid1_idle", bus.rvalid1, 0);
    end
    chk("gnt0", bus.gnt0, eg0);
    chk("gnt1", bus.gnt1, eg1);
    if (eg0 && !w0) q.push_back('{1'b0, er});
    if (eg1 && !w1) q.push_back('{1'b1, er});
    @(negedge clk);
  endtask
  task automatic sweep();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("sweep_wena", bus.m_wena, 1);
      chk("sweep_addr", bus.m_w_addr, i);
      chk("sweep_word", bus.m_w_word, 0);
      chk("sweep_gnt0", bus.gnt0, 0);
      chk("sweep_done", bus.init_done, 0);
      @(negedge clk);
    end
    #1;
    chk("init_done", bus.init_done, 1);
  endtask
  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_rvalid0", bus.rvalid0, 0);
    chk("rst_rvalid1", bus.rvalid1, 0);
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_wena", bus.m_wena, 0);
    chk("rst_rena", bus.m_rena, 0);
    chk("rst_waddr", bus.m_w_addr, 0);
    chk("rst_wword", bus.m_w_word, 0);
    chk("rst_raddr", bus.m_r_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep();
    step(1,0,0,8'h00, 0,0,0,8'h00, 1,0, 8'h00);
    step(1,1,3,8'h5A, 0,0,0,8'h00, 1,0, 8'h00);
    step(1,0,3,8'h00, 0,0,0,8'h00, 1,0, 8'h5A);
    step(0,0,0,8'h00, 0,0,0,8'h00, 0,0, 8'h00);
    step(1,0,3,8'h00, 1,0,0,8'h00, 0,1, 8'h00);
    step(1,0,3,8'h00, 1,0,0,8'h00, 1,0, 8'h5A);
    step(1,0,3,8'h00, 1,0,0,8'h00, 0,1, 8'h00);
    step(1,0,3,8'h00, 1,0,0,8'h00, 1,0, 8'h5A);
    step(0,0,0,8'h00, 1,1,5,8'hC3, 0,1, 8'h00);
    step(1,0,5,8'h00, 0,0,0,8'h00, 1,0, 8'hC3);
    step(0,0,0,8'h00, 1,0,5,8'h00, 0,1, 8'hC3);
    step(0,0,0,8'h00, 1,0,5,8'h00, 0,1, 8'hC3);
    step(0,0,0,8'h00, 1,0,5,8'h00, 0,1, 8'hC3);
    step(0,0,0,8'h00, 0,0,0,8'h00, 0,0, 8'h00);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 3'd3;
    #1;
    chk("pre_rst_gnt0", bus.gnt0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt0", bus.gnt0, 0);
    chk("mid_rst_rena", bus.m_rena, 0);
    chk("mid_rst_wena", bus.m_wena, 0);
    q.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_rvalid0", bus.rvalid0, 0);
    chk("mid_rst_rvalid1", bus.rvalid1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep();
    step(1,0,3,8'h00, 0,0,0,8'h00, 1,0, 8'h00);
    step(0,0,0,8'h00, 0,0,0,8'h00, 0,0, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
